mem_stage: RTL

- MEM stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM register and consumes its control bits, ALU result, store data and destination register number.
- It performs loads and stores against a data memory with a req/ack handshake, and supports byte, half and word access with sign or zero extension.
- It stalls the pipeline while an access is outstanding.
- Its outputs are registered, so they form the MEM/WB register feeding writeback.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage_load_align.sv | 31 +++
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: access sizes, FSM states,
// byte-enable base patterns and the watchdog counter sizing helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Watchdog counter width: enough bits for the limit, clamped to 8..16.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave).
interface mem_stage_if #(
  parameter int AW = 32
);
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load lane extraction: picks the byte/half addressed by addr[1:0] out of the
// read word and sign- or zero-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        ext_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata_i[8*gi +: 8];
  end

  always_comb begin
    byte_sel = lane[addr_i];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{ext_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{ext_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one load/store at a time on a req/ack bus, stalls
// upstream while busy and registers the MEM/WB outputs. Optional watchdog
// enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemWrite_i,
  input  logic        ExtOp_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] ALUdata_i,
  input  logic [31:0] Write_data_i,
  input  logic [4:0]  instr_i,
  output logic        stall_o,
  mem_stage_if.master mem,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUdata_o,
  output logic [4:0]  instr_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("mem_stage: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_e      state_q;
  logic [31:0] alu_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        ext_q;
  logic        rw_q;
  logic        mtr_q;
  logic [1:0]  size_q;
  logic [4:0]  rd_q;

  logic        wb_rw_q;
  logic        wb_mtr_q;
  logic [31:0] wb_read_q;
  logic [31:0] wb_alu_q;
  logic [4:0]  wb_rd_q;
  logic        misalign_q;
  logic        timeout_q;

  logic        mem_op;
  logic        aligned;
  logic        busy;
  logic        to_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_data;

  always_comb begin
    mem_op  = MemtoReg_i | MemWrite_i;
    aligned = ~|ALUdata_i[1:0];
    be_d    = BE_WORD;
    wdata_d = Write_data_i;
    case (size_i)
      SZ_BYTE: begin
        aligned = 1'b1;
        be_d    = BE_BYTE << ALUdata_i[1:0];
        wdata_d = {4{Write_data_i[7:0]}};
      end
      SZ_HALF: begin
        aligned = ~ALUdata_i[0];
        be_d    = BE_HALF << ALUdata_i[1:0];
        wdata_d = {2{Write_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign busy = (state_q == BUSY);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;
  assign to_hit = busy & ~mem.mem_ack_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Upstream may advance on the completing edge, whether by ack or watchdog.
  assign stall_o = ~rst_i & (busy ? ~(mem.mem_ack_i | to_hit) : (mem_op & aligned));

  assign mem.mem_req_o   = busy;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = {alu_q[AW-1:2], 2'b00};
  assign mem.mem_be_o    = be_q;
  assign mem.mem_wdata_o = wdata_q;

  load_align u_load_align (
    .rdata_i (mem.mem_rdata_i),
    .addr_i  (alu_q[1:0]),
    .size_i  (size_q),
    .ext_i   (ext_q),
    .data_o  (ld_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      alu_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      ext_q      <= 1'b0;
      rw_q       <= 1'b0;
      mtr_q      <= 1'b0;
      size_q     <= '0;
      rd_q       <= '0;
      wb_rw_q    <= 1'b0;
      wb_mtr_q   <= 1'b0;
      wb_read_q  <= '0;
      wb_alu_q   <= '0;
      wb_rd_q    <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          wb_read_q <= '0;
          wb_alu_q  <= ALUdata_i;
          wb_rd_q   <= instr_i;
          if (mem_op && aligned) begin
            state_q  <= BUSY;
            alu_q    <= ALUdata_i;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= MemWrite_i;
            ext_q    <= ExtOp_i;
            rw_q     <= RegWrite_i & ~MemWrite_i;
            mtr_q    <= MemtoReg_i;
            size_q   <= size_i;
            rd_q     <= instr_i;
            wb_rw_q  <= 1'b0;
            wb_mtr_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end else if (mem_op) begin
            misalign_q <= 1'b1;
            wb_rw_q    <= 1'b0;
            wb_mtr_q   <= 1'b0;
          end else begin
            wb_rw_q  <= RegWrite_i;
            wb_mtr_q <= MemtoReg_i;
          end
        end
        BUSY: begin
          if (mem.mem_ack_i) begin
            state_q   <= IDLE;
            wb_rw_q   <= rw_q;
            wb_mtr_q  <= mtr_q;
            wb_read_q <= we_q ? 32'd0 : ld_data;
            wb_alu_q  <= alu_q;
            wb_rd_q   <= rd_q;
          end else if (to_hit) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
            wb_rw_q   <= 1'b0;
            wb_mtr_q  <= 1'b0;
            wb_read_q <= '0;
          end else begin
            wb_rw_q   <= 1'b0;
            wb_mtr_q  <= 1'b0;
            wb_read_q <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RegWrite_o = wb_rw_q;
  assign MemtoReg_o = wb_mtr_q;
  assign ReadData_o = wb_read_q;
  assign ALUdata_o  = wb_alu_q;
  assign instr_o    = wb_rd_q;
  assign misalign_o = misalign_q;
  assign timeout_o  = timeout_q;

endmodule
